// File: rtl/fir2d_window_gen_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
// The master side produces pixels and consumes windows; the slave side is the generator.
interface fir2d_window_gen_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  in_sof;
    logic                  out_valid;
    logic                  out_ready;
    logic [9*DATA_W-1:0]   win_data;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, win_data
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, win_data
    );
endinterface

// File: rtl/fir2d_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a column shift
// register feed one registered window per interior pixel to the multiplier array.
module fir2d_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    fir2d_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_W-1:0]     r_lb0 [IMG_W];
    logic [DATA_W-1:0]     r_lb1 [IMG_W];
    logic [DATA_W-1:0]     r_c0  [3];
    logic [DATA_W-1:0]     r_c1  [3];
    logic                  r_out_valid;
    logic [9*DATA_W-1:0]   r_win_data;

    logic                  w_accept;
    logic                  w_emit;
    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic [DATA_W-1:0]     w_new [3];
    logic [9*DATA_W-1:0]   w_win;

    // Single output stage: a new pixel may enter only if the held window leaves.
    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_col         = bus.in_sof ? '0 : r_col;
    assign w_row         = bus.in_sof ? '0 : r_row;
    assign w_emit        = (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign bus.out_valid = r_out_valid;
    assign bus.win_data  = r_win_data;

    always_comb begin
        w_new[0] = r_lb0[w_col];
        w_new[1] = r_lb1[w_col];
        w_new[2] = bus.in_data;
    end

    // r_c0/r_c1 hold the two older columns; the incoming column completes the window.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < 3; i++) begin
            w_win[(3*i)*DATA_W   +: DATA_W] = r_c0[i];
            w_win[(3*i+1)*DATA_W +: DATA_W] = r_c1[i];
            w_win[(3*i+2)*DATA_W +: DATA_W] = w_new[i];
        end
    end

    // Line buffers are left unreset; stale entries never reach a window because
    // emission waits until two full rows of the current frame have been written.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            r_lb1[w_col] <= bus.in_data;
            r_lb0[w_col] <= r_lb1[w_col];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_win_data  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_c0[i] <= '0;
                r_c1[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_c0[i] <= r_c1[i];
                r_c1[i] <= w_new[i];
            end
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_win_data <= w_win;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir2d_window_gen.sv
// Self-checking bench for fir2d_window_gen on a 4x4 image: directed scenarios
// plus randomized handshake gaps, compared against a frame-array reference model.
module tb_fir2d_window_gen;
    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int WINW = 9 * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir2d_window_gen_if #(.DATA_W(DW)) bus ();

    fir2d_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;
    bit rmode  = 1'b0;

    logic [DW-1:0]   img [H][W];
    int              m_row = 0;
    int              m_col = 0;
    logic            exp_ov = 1'b0;
    logic [WINW-1:0] exp_win = '0;
    logic [WINW-1:0] got_q [$];
    logic [WINW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [WINW-1:0] got, input logic [WINW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [WINW-1:0] wexp(input int base, input int r0, input int c0);
        logic [WINW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*DW +: DW] = DW'(base + W*(r0+i) + c0 + j);
        return w;
    endfunction

    // Reference model: place each accepted pixel into a frame image and cut the
    // 3x3 neighbourhood ending at it; output register state follows the handshake rules.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("out_valid", WINW'(bus.out_valid), WINW'(exp_ov));
                chk("win_data", bus.win_data, exp_win);
            end
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.win_data);
            if (!rst_n) begin
                exp_ov  = 1'b0;
                exp_win = '0;
                m_row   = 0;
                m_col   = 0;
            end else if (bus.in_valid && bus.in_ready) begin
                int r, c;
                r = bus.in_sof ? 0 : m_row;
                c = bus.in_sof ? 0 : m_col;
                img[r][c] = bus.in_data;
                if (r >= 2 && c >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            exp_win[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
                    exp_ov = 1'b1;
                    exp_q.push_back(exp_win);
                end else begin
                    exp_ov = 1'b0;
                end
                c++;
                if (c == W) begin
                    c = 0;
                    r++;
                    if (r == H) r = 0;
                end
                m_row = r;
                m_col = c;
            end else if (bus.out_ready) begin
                exp_ov = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_px(input logic [DW-1:0] d, input logic sof, input bit gaps);
        int  n;
        bit  acc;
        if (gaps) begin
            bus.in_valid = 1'b0;
            idle($urandom_range(0, 1));
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", WINW'(acc), WINW'(1));
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit sof_first, input bit gaps);
        for (int p = 0; p < W*H; p++) send_px(DW'(base + p), sof_first && p == 0, gaps);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    logic [WINW-1:0] win_a;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;
        win_a = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("reset_out_valid", WINW'(bus.out_valid), '0);
        chk("reset_win_data", bus.win_data, '0);
        rst_n = 1'b1;

        // Basic frame, full throughput
        clear_q();
        send_frame(0, 1'b1, 1'b0);
        idle(3);
        chk("f1_count", WINW'(got_q.size()), WINW'(4));
        chk("f1_win0", got_q[0], win_a);
        chk("f1_win1", got_q[1], wexp(0, 0, 1));
        chk("f1_win2", got_q[2], wexp(0, 1, 0));
        chk("f1_win3", got_q[3], wexp(0, 1, 1));

        // Downstream stall right after the first window
        clear_q();
        for (int p = 0; p <= 10; p++) send_px(DW'(p), p == 0, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'd11;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", WINW'(bus.in_ready), '0);
            chk("stall_win", bus.win_data, win_a);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        for (int p = 11; p < 16; p++) send_px(DW'(p), 1'b0, 1'b0);
        idle(3);
        chk("stall_count", WINW'(got_q.size()), WINW'(4));
        chk("stall_win0", got_q[0], win_a);
        chk("stall_win1", got_q[1], wexp(0, 0, 1));
        chk("stall_win2", got_q[2], wexp(0, 1, 0));
        chk("stall_win3", got_q[3], wexp(0, 1, 1));

        // Two back-to-back frames
        clear_q();
        send_frame(0, 1'b1, 1'b0);
        send_frame(16, 1'b1, 1'b0);
        idle(3);
        chk("b2b_count", WINW'(got_q.size()), WINW'(8));
        chk("b2b_win4", got_q[4], wexp(16, 0, 0));
        chk("b2b_win7", got_q[7], wexp(16, 1, 1));

        // Mid-line resync on the 7th pixel
        clear_q();
        for (int p = 0; p < 6; p++) send_px(DW'(100 + p), 1'b0, 1'b0);
        send_frame(0, 1'b1, 1'b0);
        idle(3);
        chk("sof_count", WINW'(got_q.size()), WINW'(4));
        chk("sof_win0", got_q[0], win_a);
        chk("sof_win3", got_q[3], wexp(0, 1, 1));

        // Reset while a window is held
        for (int p = 0; p <= 10; p++) send_px(DW'(p), p == 0, 1'b0);
        chk("pre_rst_valid", WINW'(bus.out_valid), WINW'(1));
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("rst_out_valid", WINW'(bus.out_valid), '0);
        chk("rst_win_data", bus.win_data, '0);
        clear_q();
        send_frame(50, 1'b0, 1'b0);
        idle(3);
        chk("rst_count", WINW'(got_q.size()), WINW'(4));
        chk("rst_win0", got_q[0], wexp(50, 0, 0));
        chk("rst_win3", got_q[3], wexp(50, 1, 1));

        // Random gaps on both sides, random pixel data
        clear_q();
        rmode = 1'b1;
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < W*H; p++)
                send_px(DW'($urandom), p == 0, 1'b1);
        rmode = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);
        chk("rand_count", WINW'(got_q.size()), WINW'(12));
        chk("rand_model_count", WINW'(exp_q.size()), WINW'(12));
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            chk("rand_window", got_q[k], exp_q[k]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/fir2d_window_gen.md
Name: fir2d_window_gen

Overview:
- Streaming 3x3 neighbourhood generator for the 2D FIR datapath.
- Sits directly upstream of the coefficient multiplier array, which is built from AOI select cells.
- Accepts a raster-order pixel stream and buffers two image lines internally.
- Emits one registered 3x3 window per interior pixel, so the multiplier array sees all nine taps in parallel.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 64, pixels per line (>=3)
IMG_H, 64, lines per frame (>=3)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  pixel on in_data is valid
in_ready  output  1  block can accept a pixel this cycle
in_data  input  DATA_W  pixel, raster order
in_sof  input  1  start of frame; qualified by in_valid&in_ready
out_valid  output  1  win_data holds a valid window
out_ready  input  1  downstream accepts the window
win_data  output  9*DATA_W  window; tap k=3*i+j at [k*DATA_W +: DATA_W]

Behaviour:
- One clock, clk. Reset rst_n is synchronous and active-low: sampled only on a rising edge of clk.
- Reset values:
  - out_valid=0, win_data=0.
  - Column counter col=0, row counter row=0.
  - Line-buffer RAM/regs are not reset; they are masked by row/col gating.
- Transfers:
  - Accept when in_valid&in_ready.
  - Output handshake completes when out_valid&out_ready.
- in_ready = !out_valid | out_ready (combinational; single output stage, no extra skid).
- On each accepted pixel p at (row,col):
  - Line buffer LB1 yields pixel (row-1,col); LB0 yields (row-2,col).
  - Column (row-2,col),(row-1,col),(row,col) shifts into a 3-column window shift register.
  - LB0 takes the LB1 output; LB1 takes p. Each line buffer is IMG_W deep, indexed by col.
- Window emission:
  - If accepted pixel has row>=2 and col>=2: next cycle out_valid=1.
  - Window contents: tap (i,j) = pixel (row-2+i, col-2+j), with i=row offset and j=column offset, both 0..2.
  - Latency: 1 cycle from accept to out_valid.
  - Otherwise out_valid falls on the next edge if the current window was taken (or was not valid).
- Border policy: no padding. Exactly (IMG_W-2)*(IMG_H-2) windows per frame; windows never straddle lines.
- Counters:
  - col increments per accepted pixel; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0.
- in_sof on an accepted pixel forces that pixel to be (0,0), regardless of counter state. This resyncs a misaligned stream; no window is emitted for it.
- Stall: while out_valid&!out_ready:
  - win_data and out_valid hold.
  - in_ready=0; no counter or buffer update.
- Simultaneous out handshake and new accept in the same cycle: the new window replaces the old with no bubble, so full throughput is 1 pixel/cycle.
- Reset mid-frame: partial frame discarded, out_valid=0 on the next edge. The stream restarts at (0,0) with the next accepted pixel.
- win_data is unchanged when out_valid=0 after the last handshake. Content is don't-care, but no X after reset.

Test Plan:
- IMG_W=4, IMG_H=4; stream p=4*r+c (0..15), in_sof on pixel 0, out_ready=1 -> exactly 4 windows:
  - after pixel 10: taps k0..k8 = 0,1,2,4,5,6,8,9,10
  - then 1,2,3,5,6,7,9,10,11
  - then 4,5,6,8,9,10,12,13,14
  - then 5,6,7,9,10,11,13,14,15
  - each window appears 1 cycle after its last pixel.
- Same stream, out_ready=0 for 5 cycles after the first window -> win_data holds 0,1,..,10 and in_ready=0 throughout. After release, the remaining 3 windows arrive in order with no loss or duplication.
- Two back-to-back frames with in_valid=1 continuously -> 8 windows; the second frame's first window is 16,17,18,20,21,22,24,25,26 (same pattern, data offset +16).
- Assert in_sof mid-line, on the 7th pixel of a frame -> counters restart. The first window appears after the 11th pixel following the sof, and contains only post-sof data.
- rst_n=0 for one cycle while out_valid=1 mid-frame -> next edge out_valid=0, win_data=0. A fresh 16-pixel frame then yields exactly 4 correct windows.
- Random in_valid/out_ready gaps (about 50%), 3 frames -> window sequence matches a golden model. No window is emitted for row<2 or col<2.
